// File: rtl/lock_controller.sv
`default_nettype none
// ============================================================================
// Module      : lock_controller
// Description : Sequencer for a two-gate canal lock. Serves boats arriving at
//               the low or high gate, moving the chamber water level between
//               the two sides, and drives the status flags and countdown
//               values shown on the seven-segment display.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   system clock, all logic on posedge
//   reset      in   synchronous active-high reset
//   tick       in   one-clk time-unit strobe driving all countdowns
//   arrive_lo  in   one-clk pulse, boat at the low-side gate
//   arrive_hi  in   one-clk pulse, boat at the high-side gate
//   draining   out  chamber draining
//   filling    out  chamber filling
//   waiting    out  boat entering or exiting
//   drainVal   out  drain countdown (0 when not draining)
//   fillVal    out  fill countdown  (0 when not filling)
//   waitVal    out  wait countdown  (0 when not waiting)
//   gate_lo    out  low-side gate open
//   gate_hi    out  high-side gate open
//   level      out  chamber level, 0 = low, 1 = high
//   busy       out  sequencer not idle
//   pend_lo    out  low-side request queued
//   pend_hi    out  high-side request queued
// ============================================================================
module lock_controller #(
    parameter int FILL_TIME  = 7,
    parameter int DRAIN_TIME = 8,
    parameter int WAIT_TIME  = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       arrive_lo,
    input  logic       arrive_hi,
    output logic       draining,
    output logic       filling,
    output logic       waiting,
    output logic [3:0] drainVal,
    output logic [3:0] fillVal,
    output logic [3:0] waitVal,
    output logic       gate_lo,
    output logic       gate_hi,
    output logic       level,
    output logic       busy,
    output logic       pend_lo,
    output logic       pend_hi
);

    localparam logic [3:0] c_FILL_LOAD  = 4'(FILL_TIME);
    localparam logic [3:0] c_DRAIN_LOAD = 4'(DRAIN_TIME);
    localparam logic [3:0] c_WAIT_LOAD  = 4'(WAIT_TIME);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PREP  = 3'd1,
        ENTER = 3'd2,
        MOVE  = 3'd3,
        EXIT  = 3'd4
    } state_t;

    // Core sequencer state
    state_t     r_state;
    logic       r_side;      // 0 = boat from low side, 1 = boat from high side
    logic       r_level;
    logic [3:0] r_cnt;
    logic       r_pend_lo;
    logic       r_pend_hi;

    // Registered display / gate outputs
    logic       r_draining;
    logic       r_filling;
    logic       r_waiting;
    logic [3:0] r_drain_val;
    logic [3:0] r_fill_val;
    logic [3:0] r_wait_val;
    logic       r_gate_lo;
    logic       r_gate_hi;
    logic       r_busy;

    // Next-state values
    state_t     w_state_nxt;
    logic       w_side_nxt;
    logic       w_level_nxt;
    logic [3:0] w_cnt_nxt;
    logic       w_pend_lo_nxt;
    logic       w_pend_hi_nxt;
    logic       w_draining_nxt;
    logic       w_filling_nxt;
    logic       w_waiting_nxt;
    logic [3:0] w_drain_val_nxt;
    logic [3:0] w_fill_val_nxt;
    logic [3:0] w_wait_val_nxt;
    logic       w_gate_lo_nxt;
    logic       w_gate_hi_nxt;
    logic       w_busy_nxt;

    logic       w_level_phase_nxt;
    logic [3:0] w_move_load;

    // A level-changing phase always moves away from the current level,
    // so its load value follows directly from the level register.
    assign w_move_load = r_level ? c_DRAIN_LOAD : c_FILL_LOAD;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_side      <= 1'b0;
            r_level     <= 1'b0;
            r_cnt       <= 4'd0;
            r_pend_lo   <= 1'b0;
            r_pend_hi   <= 1'b0;
            r_draining  <= 1'b0;
            r_filling   <= 1'b0;
            r_waiting   <= 1'b0;
            r_drain_val <= 4'd0;
            r_fill_val  <= 4'd0;
            r_wait_val  <= 4'd0;
            r_gate_lo   <= 1'b0;
            r_gate_hi   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_side      <= w_side_nxt;
            r_level     <= w_level_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pend_lo   <= w_pend_lo_nxt;
            r_pend_hi   <= w_pend_hi_nxt;
            r_draining  <= w_draining_nxt;
            r_filling   <= w_filling_nxt;
            r_waiting   <= w_waiting_nxt;
            r_drain_val <= w_drain_val_nxt;
            r_fill_val  <= w_fill_val_nxt;
            r_wait_val  <= w_wait_val_nxt;
            r_gate_lo   <= w_gate_lo_nxt;
            r_gate_hi   <= w_gate_hi_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_side_nxt    = r_side;
        w_level_nxt   = r_level;
        w_cnt_nxt     = r_cnt;
        // One-deep request queue per side; a pulse while already queued is
        // absorbed by the OR.
        w_pend_lo_nxt = r_pend_lo | arrive_lo;
        w_pend_hi_nxt = r_pend_hi | arrive_hi;

        case (r_state)
            IDLE: begin
                // A side already at its own level needs no chamber move and
                // takes priority over the other side.
                if (r_pend_lo && !r_level) begin
                    w_state_nxt   = ENTER;
                    w_side_nxt    = 1'b0;
                    w_cnt_nxt     = c_WAIT_LOAD;
                    w_pend_lo_nxt = 1'b0;
                end else if (r_pend_hi && r_level) begin
                    w_state_nxt   = ENTER;
                    w_side_nxt    = 1'b1;
                    w_cnt_nxt     = c_WAIT_LOAD;
                    w_pend_hi_nxt = 1'b0;
                end else if (r_pend_lo) begin
                    w_state_nxt   = PREP;
                    w_side_nxt    = 1'b0;
                    w_cnt_nxt     = w_move_load;
                    w_pend_lo_nxt = 1'b0;
                end else if (r_pend_hi) begin
                    w_state_nxt   = PREP;
                    w_side_nxt    = 1'b1;
                    w_cnt_nxt     = w_move_load;
                    w_pend_hi_nxt = 1'b0;
                end
            end
            PREP, ENTER, MOVE, EXIT: begin
                if (tick) begin
                    if (r_cnt != 4'd0) begin
                        w_cnt_nxt = r_cnt - 4'd1;
                    end else begin
                        // Phase complete: a tick seen with the count at zero
                        case (r_state)
                            PREP: begin
                                w_state_nxt = ENTER;
                                w_level_nxt = ~r_level;
                                w_cnt_nxt   = c_WAIT_LOAD;
                            end
                            ENTER: begin
                                w_state_nxt = MOVE;
                                w_cnt_nxt   = w_move_load;
                            end
                            MOVE: begin
                                w_state_nxt = EXIT;
                                w_level_nxt = ~r_level;
                                w_cnt_nxt   = c_WAIT_LOAD;
                            end
                            default: begin
                                w_state_nxt = IDLE;
                                w_cnt_nxt   = 4'd0;
                            end
                        endcase
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase

        // Outputs are decoded from the next state so they are registered
        // alongside it and change on the same edge.
        w_level_phase_nxt = (w_state_nxt == PREP) || (w_state_nxt == MOVE);
        w_draining_nxt    = w_level_phase_nxt &&  w_level_nxt;
        w_filling_nxt     = w_level_phase_nxt && !w_level_nxt;
        w_waiting_nxt     = (w_state_nxt == ENTER) || (w_state_nxt == EXIT);
        w_drain_val_nxt   = w_draining_nxt ? w_cnt_nxt : 4'd0;
        w_fill_val_nxt    = w_filling_nxt  ? w_cnt_nxt : 4'd0;
        w_wait_val_nxt    = w_waiting_nxt  ? w_cnt_nxt : 4'd0;
        // Boat enters through its own gate and leaves through the other one.
        w_gate_lo_nxt     = ((w_state_nxt == ENTER) && !w_side_nxt) ||
                            ((w_state_nxt == EXIT)  &&  w_side_nxt);
        w_gate_hi_nxt     = ((w_state_nxt == ENTER) &&  w_side_nxt) ||
                            ((w_state_nxt == EXIT)  && !w_side_nxt);
        w_busy_nxt        = (w_state_nxt != IDLE);
    end

    assign draining = r_draining;
    assign filling  = r_filling;
    assign waiting  = r_waiting;
    assign drainVal = r_drain_val;
    assign fillVal  = r_fill_val;
    assign waitVal  = r_wait_val;
    assign gate_lo  = r_gate_lo;
    assign gate_hi  = r_gate_hi;
    assign level    = r_level;
    assign busy     = r_busy;
    assign pend_lo  = r_pend_lo;
    assign pend_hi  = r_pend_hi;

endmodule
`default_nettype wire

// File: tb/tb_lock_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_lock_controller
// Description : Scoreboard testbench for lock_controller. Stimulus pushes the
//               expected output snapshot for a given clock into a queue; a
//               monitor compares the DUT outputs when that clock arrives.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lock_controller;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       arrive_lo;
    logic       arrive_hi;
    logic       draining;
    logic       filling;
    logic       waiting;
    logic [3:0] drainVal;
    logic [3:0] fillVal;
    logic [3:0] waitVal;
    logic       gate_lo;
    logic       gate_hi;
    logic       level;
    logic       busy;
    logic       pend_lo;
    logic       pend_hi;

    lock_controller #(
        .FILL_TIME (7),
        .DRAIN_TIME(8),
        .WAIT_TIME (5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .arrive_lo(arrive_lo),
        .arrive_hi(arrive_hi),
        .draining (draining),
        .filling  (filling),
        .waiting  (waiting),
        .drainVal (drainVal),
        .fillVal  (fillVal),
        .waitVal  (waitVal),
        .gate_lo  (gate_lo),
        .gate_hi  (gate_hi),
        .level    (level),
        .busy     (busy),
        .pend_lo  (pend_lo),
        .pend_hi  (pend_hi)
    );

    typedef struct packed {
        logic       dr;
        logic       fl;
        logic       wt;
        logic [3:0] dv;
        logic [3:0] fv;
        logic [3:0] wv;
        logic       glo;
        logic       ghi;
        logic       lvl;
        logic       bsy;
        logic       plo;
        logic       phi;
    } outv_t;

    typedef struct {
        int    cyc;
        outv_t exp;
        string name;
    } item_t;

    item_t sb[$];
    int    cyc      = 0;
    int    checks   = 0;
    int    failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected-value builders for the four kinds of output snapshot
    function automatic outv_t o_idle(input logic lvl, input logic plo, input logic phi);
        outv_t o;
        o = '0;
        o.lvl = lvl; o.plo = plo; o.phi = phi;
        return o;
    endfunction

    function automatic outv_t o_wait(input logic [3:0] v, input logic glo, input logic ghi,
                                     input logic lvl, input logic plo, input logic phi);
        outv_t o;
        o = '0;
        o.wt = 1'b1; o.wv = v; o.glo = glo; o.ghi = ghi;
        o.lvl = lvl; o.bsy = 1'b1; o.plo = plo; o.phi = phi;
        return o;
    endfunction

    function automatic outv_t o_fill(input logic [3:0] v, input logic plo, input logic phi);
        outv_t o;
        o = '0;
        o.fl = 1'b1; o.fv = v; o.lvl = 1'b0; o.bsy = 1'b1; o.plo = plo; o.phi = phi;
        return o;
    endfunction

    function automatic outv_t o_drain(input logic [3:0] v, input logic plo, input logic phi);
        outv_t o;
        o = '0;
        o.dr = 1'b1; o.dv = v; o.lvl = 1'b1; o.bsy = 1'b1; o.plo = plo; o.phi = phi;
        return o;
    endfunction

    function automatic string fmt(input outv_t o);
        return $sformatf("dr=%0d fl=%0d wt=%0d dv=%0d fv=%0d wv=%0d glo=%0d ghi=%0d lvl=%0d busy=%0d plo=%0d phi=%0d",
                         o.dr, o.fl, o.wt, o.dv, o.fv, o.wv, o.glo, o.ghi, o.lvl, o.bsy, o.plo, o.phi);
    endfunction

    // Monitor: compares the DUT outputs whenever a scoreboard entry falls due
    always @(negedge clk) begin
        outv_t act;
        item_t it;
        act = '{draining, filling, waiting, drainVal, fillVal, waitVal,
                gate_lo, gate_hi, level, busy, pend_lo, pend_hi};
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            it = sb.pop_front();
            checks++;
            if (it.cyc < cyc) begin
                failures++;
                $display("FAIL %s: entry for clk %0d not checked in time (now %0d)", it.name, it.cyc, cyc);
            end else if (act !== it.exp) begin
                failures++;
                $display("FAIL %s @clk %0d: got [%s] expected [%s]", it.name, cyc, fmt(act), fmt(it.exp));
            end
        end
    end

    // Drive one clock's worth of inputs, set up half a period before the edge
    task automatic drv(input logic tk, input logic alo, input logic ahi, input logic rs);
        @(negedge clk);
        tick      = tk;
        arrive_lo = alo;
        arrive_hi = ahi;
        reset     = rs;
    endtask

    // Expected outputs after the edge that follows the most recent drv
    task automatic exp_next(input string nm, input outv_t e);
        item_t it;
        it.cyc  = cyc + 1;
        it.exp  = e;
        it.name = nm;
        sb.push_back(it);
    endtask

    task automatic tk_exp(input int n, input string nm, input outv_t e);
        repeat (n) drv(1'b1, 1'b0, 1'b0, 1'b0);
        exp_next(nm, e);
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; arrive_lo = 1'b0; arrive_hi = 1'b0;

        // Reset held for two clocks
        drv(0, 0, 0, 1);
        drv(0, 0, 0, 1); exp_next("reset_state", o_idle(0, 0, 0));
        drv(0, 0, 0, 0); exp_next("idle_after_reset", o_idle(0, 0, 0));

        // Low-side boat at level 0: no prep, straight to ENTER
        drv(0, 1, 0, 0); exp_next("capture_lo", o_idle(0, 1, 0));
        drv(1, 0, 0, 0); exp_next("lo_enter", o_wait(5, 1, 0, 0, 0, 0));
        tk_exp(5, "lo_enter_cnt0", o_wait(0, 1, 0, 0, 0, 0));
        tk_exp(1, "lo_move_fill", o_fill(7, 0, 0));
        drv(0, 0, 0, 0); exp_next("no_tick_hold", o_fill(7, 0, 0));
        tk_exp(7, "lo_fill_cnt0", o_fill(0, 0, 0));
        tk_exp(1, "lo_exit", o_wait(5, 0, 1, 1, 0, 0));
        tk_exp(6, "lo_done", o_idle(1, 0, 0));

        // Reset returns the chamber level to low
        drv(0, 0, 0, 1); exp_next("reset_level", o_idle(0, 0, 0));

        // High-side boat at level 0: PREP fill first
        drv(0, 0, 1, 0); exp_next("capture_hi", o_idle(0, 0, 1));
        drv(0, 0, 0, 0); exp_next("hi_prep_fill", o_fill(7, 0, 0));
        tk_exp(8, "hi_enter", o_wait(5, 0, 1, 1, 0, 0));
        tk_exp(6, "hi_move_drain", o_drain(8, 0, 0));
        tk_exp(9, "hi_exit", o_wait(5, 1, 0, 0, 0, 0));
        tk_exp(6, "hi_done", o_idle(0, 0, 0));

        // Both sides at once, level 0: low first, then high with no PREP
        drv(0, 1, 1, 0); exp_next("capture_both", o_idle(0, 1, 1));
        drv(0, 0, 0, 0); exp_next("both_lo_enter", o_wait(5, 1, 0, 0, 0, 1));
        tk_exp(6, "both_lo_move", o_fill(7, 0, 1));
        tk_exp(8, "both_lo_exit", o_wait(5, 0, 1, 1, 0, 1));
        tk_exp(6, "both_lo_done", o_idle(1, 0, 1));
        drv(0, 0, 0, 0); exp_next("both_hi_enter", o_wait(5, 0, 1, 1, 0, 0));
        tk_exp(6, "both_hi_move", o_drain(8, 0, 0));
        tk_exp(9, "both_hi_exit", o_wait(5, 1, 0, 0, 0, 0));
        tk_exp(6, "both_hi_done", o_idle(0, 0, 0));

        // Three low arrivals during MOVE queue exactly one extra service
        drv(0, 1, 0, 0); exp_next("dup_capture", o_idle(0, 1, 0));
        drv(0, 0, 0, 0); exp_next("dup_enter", o_wait(5, 1, 0, 0, 0, 0));
        tk_exp(6, "dup_move", o_fill(7, 0, 0));
        repeat (3) begin
            drv(0, 1, 0, 0);
            drv(0, 0, 0, 0);
        end
        exp_next("dup_pend_once", o_fill(7, 1, 0));
        tk_exp(8, "dup_exit", o_wait(5, 0, 1, 1, 1, 0));
        tk_exp(6, "dup_idle_pend", o_idle(1, 1, 0));
        drv(0, 0, 0, 0); exp_next("dup_prep_drain", o_drain(8, 0, 0));
        tk_exp(9, "dup_enter2", o_wait(5, 1, 0, 0, 0, 0));
        tk_exp(6, "dup_move2", o_fill(7, 0, 0));
        tk_exp(8, "dup_exit2", o_wait(5, 0, 1, 1, 0, 0));
        tk_exp(6, "dup_done", o_idle(1, 0, 0));
        repeat (3) drv(0, 0, 0, 0);
        exp_next("dup_no_extra", o_idle(1, 0, 0));

        // Reset in the middle of a drain with drainVal = 3
        drv(0, 0, 1, 0); exp_next("g_capture_hi", o_idle(1, 0, 1));
        drv(0, 0, 0, 0); exp_next("g_enter", o_wait(5, 0, 1, 1, 0, 0));
        tk_exp(6, "g_move_drain", o_drain(8, 0, 0));
        tk_exp(5, "g_drain3", o_drain(3, 0, 0));
        drv(0, 1, 0, 0); exp_next("g_pend_lo", o_drain(3, 1, 0));
        drv(1, 0, 0, 1); exp_next("g_reset_abort", o_idle(0, 0, 0));
        drv(0, 0, 0, 0); exp_next("g_stay_idle", o_idle(0, 0, 0));

        drv(0, 0, 0, 0);
        drv(0, 0, 0, 0);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lock_controller.md
Name: lock_controller

Overview:
- Sequences a two-gate water lock (canal chamber) for boats arriving at the low side or the high side.
- Drives the draining/filling/waiting status flags and their 4-bit countdown values consumed by the seven-segment display block.
- Also drives both gate enables, tracks the chamber water level, and queues one pending request per side.
- Time base is an external single-cycle `tick` strobe.

Parameters:
- FILL_TIME, 7, tick count loaded into fillVal at the start of a fill phase; legal 1..8.
- DRAIN_TIME, 8, tick count loaded into drainVal at the start of a drain phase; legal 1..8.
- WAIT_TIME, 5, tick count loaded into waitVal at the start of an enter/exit phase; legal 1..8.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous active-high reset.
- tick  in  1  one-clk time-unit strobe.
- arrive_lo  in  1  one-clk pulse: boat arrives at the low-side gate.
- arrive_hi  in  1  one-clk pulse: boat arrives at the high-side gate.
- draining  out  1  chamber draining; to display.
- filling  out  1  chamber filling; to display.
- waiting  out  1  boat entering or exiting; to display.
- drainVal  out  4  drain countdown; to display.
- fillVal  out  4  fill countdown; to display.
- waitVal  out  4  wait countdown; to display.
- gate_lo  out  1  low-side gate open.
- gate_hi  out  1  high-side gate open.
- level  out  1  chamber level: 0 = low, 1 = high.
- busy  out  1  FSM not in IDLE.
- pend_lo  out  1  low-side request queued.
- pend_hi  out  1  high-side request queued.

Behaviour:
- Clock and reset: one clock (`clk`). Reset is synchronous and active-high (`reset`).
- Outputs: all registered.
- Reset values: state IDLE; level 0; every other output 0; pending bits clear.
- Reset mid-operation: aborts on the next posedge regardless of state. Gates close, level returns to 0, queued requests are discarded.
- Request capture: arrive_x sets pend_x on the next posedge. A pulse while pend_x is already 1 is ignored (one-deep per side). Arrivals are captured in every state.
- States: IDLE, PREP, ENTER, MOVE, EXIT. Register `side` holds the side currently being served.
- IDLE dispatch (evaluated every clk on registered pend bits, so dispatch is one clk after the arrive pulse; tick not required):
  - Pending side whose level matches (lo with level 0, hi with level 1): go to ENTER. This side wins if both are pending.
  - Otherwise, if the other side is pending: go to PREP.
  - The served pend bit clears on the dispatch edge.
- PREP:
  - Gates closed.
  - Moves the empty chamber to the boat's level: filling=1 with fillVal=FILL_TIME if level 0; draining=1 with drainVal=DRAIN_TIME if level 1.
  - On completion: toggle level, go to ENTER.
- ENTER:
  - waiting=1, waitVal=WAIT_TIME.
  - gate on `side` open.
  - On completion go to MOVE.
- MOVE:
  - Gates closed.
  - Fill or drain exactly as in PREP, in the direction away from the current level.
  - On completion: toggle level, go to EXIT.
- EXIT:
  - waiting=1, waitVal=WAIT_TIME.
  - Gate opposite `side` open.
  - On completion go to IDLE.
- Countdown rule (all timed phases): value loaded on the state-entry edge. Each tick with value>0 decrements it. A tick with value==0 completes the phase. A phase with load N therefore lasts N+1 ticks.
- Flag and value exclusivity: at most one of draining/filling/waiting is 1 at any time. The value of any inactive flag is held at 0. In IDLE all three flags are 0.
- Gate exclusivity: gate_lo and gate_hi are never both 1. Both are 0 during PREP and MOVE.
- busy=1 in every state except IDLE.
- tick in IDLE: no effect.
- tick on the same clk as a state-entry edge: not counted.
- Level changes only on completion of PREP or MOVE.

Test Plan:
- Reset: assert reset 2 clks, mid-stream -> all outputs 0, level=0, busy=0, pend_lo=pend_hi=0.
- Matched-side arrival, level 0:
  - arrive_lo -> next clk waiting=1, waitVal=5, gate_lo=1, pend_lo=0.
  - After 6 ticks: filling=1, fillVal=7, gates 0.
  - After 8 more ticks: level=1, waiting=1, gate_hi=1.
  - After 6 more ticks: busy=0.
- Opposite-side arrival, level 0:
  - arrive_hi -> PREP with filling=1, fillVal=7, gates 0.
  - After 8 ticks: level=1, gate_hi=1, waitVal=5.
  - Then MOVE with draining=1, drainVal=8 for 9 ticks.
  - Then EXIT with gate_lo=1, ending with level=0.
- Simultaneous arrive_lo and arrive_hi at level 0:
  - Low served first with no PREP; pend_hi stays 1 throughout.
  - After its EXIT (level=1), the high side is served directly via ENTER with gate_hi=1, no PREP.
- Duplicate and busy arrivals:
  - Three arrive_lo pulses during a MOVE -> pend_lo=1 once; exactly one additional service cycle follows.
- Reset mid-MOVE with drainVal=3:
  - Next clk: draining=0, drainVal=0, gates 0, level=0, busy=0, pendings cleared.
